// File: rtl/rgb2gray_stream.sv
// Streaming RGB-to-gray converter: 3-stage weighted-luma (round + saturate) or
// channel-max datapath with valid/ready backpressure and a per-frame pixel counter.
module rgb2gray_stream #(
  parameter int COLOR_SIZE  = 8,
  parameter int WEIGHT_SIZE = 8,
  parameter int FRAC_BITS   = 8,
  parameter int W_R         = 77,
  parameter int W_G         = 150,
  parameter int W_B         = 29,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  mode_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [COLOR_SIZE-1:0] in_r_i,
  input  logic [COLOR_SIZE-1:0] in_g_i,
  input  logic [COLOR_SIZE-1:0] in_b_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [COLOR_SIZE-1:0] out_gray_o,
  output logic                  out_last_o,
  output logic [CNT_WIDTH-1:0]  pix_count_o,
  output logic                  frame_done_o
);

  localparam int STAGES = 3;
  localparam int PW     = COLOR_SIZE + WEIGHT_SIZE;
  localparam int SW     = PW + 2;

  localparam logic [PW-1:0] WR    = PW'(W_R);
  localparam logic [PW-1:0] WG    = PW'(W_G);
  localparam logic [PW-1:0] WB    = PW'(W_B);
  localparam logic [SW-1:0] RND   = SW'(1) << (FRAC_BITS - 1);
  localparam logic [SW-1:0] G_MAX = {{(SW-COLOR_SIZE){1'b0}}, {COLOR_SIZE{1'b1}}};

  typedef struct packed {
    logic          mode;
    logic          last;
    logic [PW-1:0] pr;   // holds max(R,G,B) in mode 1
    logic [PW-1:0] pg;
    logic [PW-1:0] pb;
  } s1_t;

  typedef struct packed {
    logic          mode;
    logic          last;
    logic [SW-1:0] sum;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic [COLOR_SIZE-1:0] gray_d;
  logic [SW-1:0]   q_ext;
  logic [COLOR_SIZE-1:0] ch_max;
  logic            adv, adv_en, in_fire, out_fire;

  assign adv        = ~vld_pipe[STAGES] | out_ready_i;
  assign adv_en     = adv & ~clear_i;
  assign in_ready_o = adv & ~clear_i;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = vld_pipe[STAGES] & out_ready_i & ~clear_i;
  assign out_valid_o = vld_pipe[STAGES];

  always_comb begin
    ch_max = in_r_i;
    if (in_g_i > ch_max) ch_max = in_g_i;
    if (in_b_i > ch_max) ch_max = in_b_i;
  end

  always_comb begin
    s1_d      = '0;
    s1_d.mode = mode_i;
    s1_d.last = in_last_i;
    if (mode_i) begin
      s1_d.pr = PW'(ch_max);
    end else begin
      s1_d.pr = PW'(in_r_i) * WR;
      s1_d.pg = PW'(in_g_i) * WG;
      s1_d.pb = PW'(in_b_i) * WB;
    end
  end

  always_comb begin
    s2_d      = '0;
    s2_d.mode = s1_q.mode;
    s2_d.last = s1_q.last;
    if (s1_q.mode) s2_d.sum = SW'(s1_q.pr);
    else           s2_d.sum = SW'(s1_q.pr) + SW'(s1_q.pg) + SW'(s1_q.pb) + RND;
  end

  always_comb begin
    q_ext  = s2_q.sum >> FRAC_BITS;
    gray_d = s2_q.sum[COLOR_SIZE-1:0];
    if (!s2_q.mode) gray_d = (q_ext > G_MAX) ? {COLOR_SIZE{1'b1}} : q_ext[COLOR_SIZE-1:0];
  end

  // Valid bits shift as a unit; bubbles are kept, not compressed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       vld_pipe <= '0;
    else if (clear_i) vld_pipe <= '0;
    else if (adv)     vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};
  end

  always_ff @(posedge clk_i) begin
    if (adv_en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_gray_o <= '0;
      out_last_o <= 1'b0;
    end else if (adv_en) begin
      out_gray_o <= gray_d;
      out_last_o <= s2_q.last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pix_count_o  <= '0;
      frame_done_o <= 1'b0;
    end else if (clear_i) begin
      pix_count_o  <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= out_fire & out_last_o;
      if (out_fire) pix_count_o <= out_last_o ? '0 : pix_count_o + 1'b1;
    end
  end

endmodule
